axis_seq_checker: RTL

- AXI-Stream slave endpoint (sink) that consumes a stream, checks it against an incrementing-count reference pattern and checks frame length via tlast.
- Generates programmable backpressure on s_axis_tready to exercise upstream stream stages such as register slices and FIFOs.
- Sits at the downstream end of an AXI-S path in loopback/self-test builds.
- Exposes frame, beat and error counters plus first-error capture to a status register block.

---
 rtl/axis_seq_checker_pkg.sv | 21 ++
 rtl/axis_ready_shaper.sv | 38 +++
 rtl/axis_seq_checker.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/axis_seq_checker_pkg.sv
// Shared types and helpers for the AXI-Stream sequence checker.
// Holds the FSM state encoding and the saturating counter step.
package axis_seq_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Step to add to a w-bit counter: 1 below all-ones, 0 at all-ones.
  function automatic logic sat_inc(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] top;
    top = ~64'd0 >> (64 - w);
    return v != top;
  endfunction

endpackage

// File: rtl/axis_ready_shaper.sv
// Rotating-mask throttle: drives a registered ready/valid
// from a pattern loaded at start and rotated right each cycle.
module axis_ready_shaper #(
  parameter int MASK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_run,
  input  logic [MASK_WIDTH-1:0] i_mask,
  output logic                  o_ready
);

  logic [MASK_WIDTH-1:0] r_mask;
  logic [MASK_WIDTH-1:0] w_rot;
  logic                  r_ready;

  assign w_rot = {r_mask[0], r_mask[MASK_WIDTH-1:1]};

  // Output bit tracks the mask LSB the mask register will hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask  <= '0;
      r_ready <= 1'b0;
    end else if (i_load) begin
      r_mask  <= i_mask;
      r_ready <= i_mask[0];
    end else if (i_run) begin
      r_mask  <= w_rot;
      r_ready <= w_rot[0];
    end else begin
      r_ready <= 1'b0;
    end
  end

  assign o_ready = r_ready;

endmodule

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink checking an incrementing pattern and tlast
// framing, with programmable backpressure and error capture.
module axis_seq_checker
  import axis_seq_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int MASK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] cfg_start_value,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [MASK_WIDTH-1:0] cfg_ready_mask,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  error_flag,
  output logic [DATA_WIDTH-1:0] err_data,
  output logic [DATA_WIDTH-1:0] err_expected
);

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0] r_expected;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_bif;
  logic [CNT_WIDTH-1:0]  r_frames;
  logic [CNT_WIDTH-1:0]  r_beats;
  logic [CNT_WIDTH-1:0]  r_errs;
  logic                  r_err_flag;
  logic [DATA_WIDTH-1:0] r_err_data;
  logic [DATA_WIDTH-1:0] r_err_exp;

  logic w_accept;
  logic w_len_chk;
  logic w_last_exp;
  logic w_data_err;
  logic w_len_err;
  logic w_err;
  logic w_frame_end;
  logic w_load;
  logic w_run;

  assign w_accept    = s_axis_tvalid & s_axis_tready;
  assign w_len_chk   = (r_len != '0);
  assign w_last_exp  = w_len_chk &&
                       (r_bif == r_len - LEN_WIDTH'(1));
  assign w_data_err  = (s_axis_tdata != r_expected);
  assign w_len_err   = w_len_chk &&
                       (s_axis_tlast != w_last_exp);
  assign w_err       = w_data_err | w_len_err;
  assign w_frame_end = s_axis_tlast | w_last_exp;
  assign w_load      = (r_state == IDLE) & enable;
  assign w_run       = (r_state != IDLE) & (w_next != IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (enable) w_next = RX;
      end
      RX: begin
        if (!enable) w_next = (r_bif == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enable)
          w_next = RX;
        else if (w_accept && w_frame_end)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  axis_ready_shaper #(
    .MASK_WIDTH(MASK_WIDTH)
  ) u_shaper (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_run  (w_run),
    .i_mask (cfg_ready_mask),
    .o_ready(s_axis_tready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_expected <= '0;
      r_len      <= '0;
      r_bif      <= '0;
      r_frames   <= '0;
      r_beats    <= '0;
      r_errs     <= '0;
      r_err_flag <= 1'b0;
      r_err_data <= '0;
      r_err_exp  <= '0;
    end else if (w_load) begin
      r_expected <= cfg_start_value;
      r_len      <= cfg_frame_len;
      r_bif      <= '0;
    end else if (w_accept) begin
      r_beats <= r_beats + CNT_WIDTH'(1);
      // A bad word resyncs the pattern to the received data.
      r_expected <= w_data_err ?
                    s_axis_tdata + DATA_WIDTH'(1) :
                    r_expected + DATA_WIDTH'(1);
      r_bif <= w_frame_end ? '0 : r_bif + LEN_WIDTH'(1);
      if (s_axis_tlast)
        r_frames <= r_frames + CNT_WIDTH'(1);
      if (w_err) begin
        r_errs <= r_errs +
                  CNT_WIDTH'(sat_inc(64'(r_errs), CNT_WIDTH));
        if (!r_err_flag) begin
          r_err_flag <= 1'b1;
          r_err_data <= s_axis_tdata;
          r_err_exp  <= r_expected;
        end
      end
    end
  end

  assign busy         = (r_state != IDLE);
  assign frame_count  = r_frames;
  assign beat_count   = r_beats;
  assign error_count  = r_errs;
  assign error_flag   = r_err_flag;
  assign err_data     = r_err_data;
  assign err_expected = r_err_exp;

endmodule
